rr_arb_2x1: RTL and testbench
=============================

// Module: rr_arb_2x1
// PURPOSE
//   Two-requester round-robin arbiter. Drives S0 of the downstream mux_2x1
//   stage, selecting which source (A or B) reaches Y.
//   - Holds each grant for a whole burst. A burst ends on a LAST-marked beat
//     or on a MAX_BEATS fairness limit.
//   - Exports a VALID/READY handshake, so the consumer of Y knows when a beat
//     is transferred.
// PARAMETERS
//   MAX_BEATS  16  beats per grant before a forced release; 0 = no limit
//   CNT_W      5   beat-counter width; must hold MAX_BEATS
// PORTS
//   CLK     in   1  clock, rising edge
//   RST     in   1  synchronous reset, active-high
//   REQ_A   in   1  source A has a beat to send
//   REQ_B   in   1  source B has a beat to send
//   LAST_A  in   1  current A beat is the last of its burst
//   LAST_B  in   1  current B beat is the last of its burst
//   READY   in   1  downstream consumer accepts a beat this cycle
//   GNT_A   out  1  A owns the mux (registered)
//   GNT_B   out  1  B owns the mux (registered)
//   S0      out  1  mux select: 0 = A, 1 = B (registered)
//   VALID   out  1  beat present on Y this cycle
// BEHAVIOUR
//   - Reset: RST sampled high sets the following on the next edge, overriding
//     everything, including mid-burst:
//     - state = IDLE, GNT_A = GNT_B = 0, S0 = 0, cnt = 0.
//     - last_winner = B, so A wins the first tie.
//     - VALID is 0 while no grant is held.
//   - States:
//     - IDLE: no grant.
//     - OWN_A: GNT_A = 1, S0 = 0.
//     - OWN_B: GNT_B = 1, S0 = 1.
//     - GNT_A and GNT_B are never both 1.
//   - VALID = (GNT_A & REQ_A) | (GNT_B & REQ_B). This is combinational from
//     the registered grant.
//   - beat = VALID & READY.
//   - Arbitration decision, made in IDLE or on release:
//     - Only one REQ high: that requester wins.
//     - Both REQ high: the requester that is not last_winner wins.
//     - No REQ high: go to IDLE.
//     - The grant appears on the next edge (1-cycle latency). last_winner
//       updates to the new owner.
//   - In IDLE, S0 holds its previous value (no needless select toggling).
//   - Release: on a beat where the owner's LAST = 1, or where
//     cnt == MAX_BEATS-1 (MAX_BEATS != 0).
//     - Arbitration runs in the same cycle, so there is no idle bubble when
//       the other side waits.
//     - The same owner may be re-granted if the other side is not requesting.
//   - cnt: +1 per beat while owned; cleared to 0 on every release.
//   - Owner drops REQ mid-burst (no LAST): the grant is held and VALID = 0.
//     No release and no timeout; cnt is unchanged.
//   - READY low: nothing changes. The grant, S0 and cnt hold.
//   - LAST while VALID = 0, or from the non-owner: ignored.
// TESTING
//   1. Reset; REQ_A = 1 one cycle later
//      -> GNT_A = 1, S0 = 0 on the next edge; VALID = 1.
//   2. REQ_A = REQ_B = 1 right after reset
//      -> A granted first.
//      -> After A's LAST beat with READY = 1, GNT_B = 1 and S0 = 1 on the
//         next edge, with no IDLE cycle.
//   3. Both requesting, bursts of 3 beats each (LAST on beat 3), READY = 1
//      -> Grants alternate A, B, A, B.
//      -> S0 toggles every 3 beats.
//   4. MAX_BEATS = 4; A streams with LAST never set, B requesting
//      -> After the 4th A beat, the grant moves to B; cnt returns to 0.
//   5. A owns the mux; READY = 0 for 5 cycles, then 1
//      -> GNT_A, S0 and cnt are stable throughout; the beat completes when
//         READY rises.
//   6. RST asserted mid-burst while B owns the mux
//      -> Next edge: GNT_B = 0, S0 = 0, VALID = 0, IDLE.
//      -> With both requesting afterwards, A wins.

Source files
------------

// File: rtl/rr_arb_2x1.sv
// rtl/rr_arb_2x1.sv - two-requester round-robin burst arbiter driving a 2:1 mux select
module rr_arb_2x1 #(
    parameter int MAX_BEATS = 16,
    parameter int CNT_W     = 5
) (
    input  logic CLK,
    input  logic RST,
    input  logic REQ_A,
    input  logic REQ_B,
    input  logic LAST_A,
    input  logic LAST_B,
    input  logic READY,
    output logic GNT_A,
    output logic GNT_B,
    output logic S0,
    output logic VALID
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((MAX_BEATS == 0) ? 0 : MAX_BEATS - 1);

    state_t           state;
    logic             last_winner_b;
    logic [CNT_W-1:0] cnt;

    logic beat;
    logic owner_last;
    logic at_limit;
    logic release_now;
    logic decide;
    logic win_a;
    logic win_b;

    always_comb begin
        VALID       = (GNT_A & REQ_A) | (GNT_B & REQ_B);
        beat        = VALID & READY;
        owner_last  = (GNT_A & LAST_A) | (GNT_B & LAST_B);
        at_limit    = (MAX_BEATS != 0) && (cnt == LIMIT);
        release_now = beat & (owner_last | at_limit);
        // Arbitrate in the release cycle itself so a waiting peer gets the next edge.
        decide      = (state == IDLE) | release_now;
        win_a       = REQ_A & (~REQ_B | last_winner_b);
        win_b       = REQ_B & ~win_a;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            GNT_A         <= 1'b0;
            GNT_B         <= 1'b0;
            S0            <= 1'b0;
            cnt           <= '0;
            last_winner_b <= 1'b1;
        end else if (decide) begin
            cnt <= '0;
            if (win_a) begin
                state         <= OWN_A;
                GNT_A         <= 1'b1;
                GNT_B         <= 1'b0;
                S0            <= 1'b0;
                last_winner_b <= 1'b0;
            end else if (win_b) begin
                state         <= OWN_B;
                GNT_A         <= 1'b0;
                GNT_B         <= 1'b1;
                S0            <= 1'b1;
                last_winner_b <= 1'b1;
            end else begin
                // S0 keeps its last value to avoid toggling the mux while idle.
                state <= IDLE;
                GNT_A <= 1'b0;
                GNT_B <= 1'b0;
            end
        end else if (beat) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_rr_arb_2x1.sv
// tb/tb_rr_arb_2x1.sv - directed self-checking bench for rr_arb_2x1
module tb_rr_arb_2x1;

    logic CLK = 1'b0;
    logic RST, REQ_A, REQ_B, LAST_A, LAST_B, READY;
    logic GNT_A, GNT_B, S0, VALID;

    int tests = 0;
    int fails = 0;

    rr_arb_2x1 #(.MAX_BEATS(4), .CNT_W(5)) dut (
        .CLK(CLK), .RST(RST),
        .REQ_A(REQ_A), .REQ_B(REQ_B),
        .LAST_A(LAST_A), .LAST_B(LAST_B),
        .READY(READY),
        .GNT_A(GNT_A), .GNT_B(GNT_B), .S0(S0), .VALID(VALID)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1; REQ_A = 1'b0; REQ_B = 1'b0;
        LAST_A = 1'b0; LAST_B = 1'b0; READY = 1'b0;
        step();
        RST = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        tests++; if (GNT_A !== 1'b0) begin fails++; $display("FAIL reset_gnt_a: got %b expected 0", GNT_A); end
        tests++; if (GNT_B !== 1'b0) begin fails++; $display("FAIL reset_gnt_b: got %b expected 0", GNT_B); end
        tests++; if (S0 !== 1'b0) begin fails++; $display("FAIL reset_s0: got %b expected 0", S0); end
        tests++; if (VALID !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", VALID); end
        tests++; if (dut.cnt !== 5'd0) begin fails++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt); end
    endtask

    task automatic test_single();
        do_reset();
        REQ_A = 1'b1; READY = 1'b1; LAST_B = 1'b1;
        #1;
        tests++; if (VALID !== 1'b0) begin fails++; $display("FAIL single_valid_pre: got %b expected 0", VALID); end
        step();
        tests++; if (GNT_A !== 1'b1 || S0 !== 1'b0) begin fails++; $display("FAIL single_grant: got gnt_a=%b s0=%b expected 1 0", GNT_A, S0); end
        tests++; if (VALID !== 1'b1) begin fails++; $display("FAIL single_valid: got %b expected 1", VALID); end
        step();
        tests++; if (dut.cnt !== 5'd1 || GNT_A !== 1'b1) begin fails++; $display("FAIL single_nonowner_last: got cnt=%0d gnt_a=%b expected 1 1", dut.cnt, GNT_A); end
        REQ_A = 1'b0; LAST_B = 1'b0;
        step();
        tests++; if (GNT_A !== 1'b1 || VALID !== 1'b0 || dut.cnt !== 5'd1) begin fails++; $display("FAIL single_drop_req: got gnt_a=%b valid=%b cnt=%0d expected 1 0 1", GNT_A, VALID, dut.cnt); end
    endtask

    task automatic test_tie();
        do_reset();
        REQ_A = 1'b1; REQ_B = 1'b1; READY = 1'b1;
        step();
        tests++; if (GNT_A !== 1'b1 || GNT_B !== 1'b0) begin fails++; $display("FAIL tie_first_a: got gnt_a=%b gnt_b=%b expected 1 0", GNT_A, GNT_B); end
        LAST_A = 1'b1;
        step();
        tests++; if (GNT_B !== 1'b1 || GNT_A !== 1'b0 || S0 !== 1'b1) begin fails++; $display("FAIL tie_handover: got gnt_a=%b gnt_b=%b s0=%b expected 0 1 1", GNT_A, GNT_B, S0); end
        tests++; if (dut.cnt !== 5'd0) begin fails++; $display("FAIL tie_cnt_clear: got %0d expected 0", dut.cnt); end
    endtask

    task automatic test_alternate();
        logic exp_a;
        do_reset();
        REQ_A = 1'b1; REQ_B = 1'b1; READY = 1'b1;
        step();
        for (int k = 0; k < 12; k++) begin
            exp_a = ((k / 3) % 2) == 0;
            tests++;
            if (GNT_A !== exp_a || GNT_B !== !exp_a || S0 !== !exp_a || VALID !== 1'b1) begin
                fails++;
                $display("FAIL alternate_beat%0d: got gnt_a=%b gnt_b=%b s0=%b valid=%b expected gnt_a=%b", k, GNT_A, GNT_B, S0, VALID, exp_a);
            end
            LAST_A = (k % 3) == 2;
            LAST_B = (k % 3) == 2;
            step();
        end
    endtask

    task automatic test_max_beats();
        do_reset();
        REQ_A = 1'b1; REQ_B = 1'b1; READY = 1'b1;
        step();
        step(); step(); step();
        tests++; if (GNT_A !== 1'b1 || dut.cnt !== 5'd3) begin fails++; $display("FAIL max_pre_limit: got gnt_a=%b cnt=%0d expected 1 3", GNT_A, dut.cnt); end
        step();
        tests++; if (GNT_B !== 1'b1 || S0 !== 1'b1 || dut.cnt !== 5'd0) begin fails++; $display("FAIL max_release: got gnt_b=%b s0=%b cnt=%0d expected 1 1 0", GNT_B, S0, dut.cnt); end
    endtask

    task automatic test_ready_stall();
        do_reset();
        REQ_A = 1'b1; READY = 1'b1;
        step();
        step();
        READY = 1'b0; REQ_B = 1'b1; LAST_A = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            tests++;
            if (GNT_A !== 1'b1 || S0 !== 1'b0 || dut.cnt !== 5'd1 || VALID !== 1'b1) begin
                fails++;
                $display("FAIL stall_cycle%0d: got gnt_a=%b s0=%b cnt=%0d valid=%b expected 1 0 1 1", i, GNT_A, S0, dut.cnt, VALID);
            end
        end
        READY = 1'b1;
        step();
        tests++; if (GNT_B !== 1'b1 || GNT_A !== 1'b0 || dut.cnt !== 5'd0) begin fails++; $display("FAIL stall_release: got gnt_a=%b gnt_b=%b cnt=%0d expected 0 1 0", GNT_A, GNT_B, dut.cnt); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        REQ_B = 1'b1; READY = 1'b1;
        step();
        step();
        tests++; if (GNT_B !== 1'b1 || S0 !== 1'b1 || dut.cnt !== 5'd1) begin fails++; $display("FAIL midrst_owned: got gnt_b=%b s0=%b cnt=%0d expected 1 1 1", GNT_B, S0, dut.cnt); end
        RST = 1'b1; REQ_A = 1'b1;
        step();
        tests++; if (GNT_B !== 1'b0 || GNT_A !== 1'b0 || S0 !== 1'b0 || VALID !== 1'b0 || dut.cnt !== 5'd0) begin fails++; $display("FAIL midrst_cleared: got gnt_a=%b gnt_b=%b s0=%b valid=%b cnt=%0d expected 0 0 0 0 0", GNT_A, GNT_B, S0, VALID, dut.cnt); end
        RST = 1'b0;
        step();
        tests++; if (GNT_A !== 1'b1 || GNT_B !== 1'b0) begin fails++; $display("FAIL midrst_a_wins: got gnt_a=%b gnt_b=%b expected 1 0", GNT_A, GNT_B); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_alternate();
        test_max_beats();
        test_ready_stall();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
